mp_add_seq: RTL and testbench

- Multi-precision add/subtract sequencer built around the team's ripple-carry adder (adderN).
- Accepts NUM_WORDS*WIDTH-bit operands and processes one WIDTH-bit word per cycle, LSW first, through a single shared adderN instance. The carry is chained between words through a register.
- Sits between a requesting controller (start/done handshake) and the arithmetic datapath. Wide additions reuse one narrow adder instead of a wide ripple chain.

---
 rtl/mp_add_seq_pkg.sv | 14 +
 rtl/mp_add_seq_adderN.sv | 25 ++
 rtl/mp_add_seq.sv | 132 +++++++++++++
 tb/tb_mp_add_seq.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mp_add_seq_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// the controller state encoding and the sizing of the word index.
package mp_add_seq_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Word-index width; kept at least 1 bit so the index register always exists.
  function automatic int idx_width(input int num_words);
    return (num_words <= 2) ? 1 : $clog2(num_words);
  endfunction

endpackage

// File: rtl/mp_add_seq_adderN.sv
// WIDTH-bit ripple-carry adder slice, shared by the sequencer for every word.
module adderN #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin_i;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum_o[gi]     = a_i[gi] ^ b_i[gi] ^ carry[gi];
      assign carry[gi + 1] = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
    end
  endgenerate

  assign cout_o = carry[WIDTH];

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: one WIDTH-bit word per cycle, LSW first,
// through a single adderN slice with the carry chained in a register.
module mp_add_seq
  import mp_add_seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int NUM_WORDS = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       sub,
  input  logic                       cin,
  input  logic [WIDTH*NUM_WORDS-1:0] a,
  input  logic [WIDTH*NUM_WORDS-1:0] b,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH*NUM_WORDS-1:0] sum,
  output logic                       cout,
  output logic                       ovf
);

  localparam int TOTW = WIDTH * NUM_WORDS;
  localparam int IDXW = idx_width(NUM_WORDS);

  logic [1:0]      state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            sub_q, sub_d;
  logic [TOTW-1:0] a_q, a_d;
  logic [TOTW-1:0] b_q, b_d;
  logic [TOTW-1:0] sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [WIDTH-1:0] a_words [NUM_WORDS];
  logic [WIDTH-1:0] b_words [NUM_WORDS];
  logic [WIDTH-1:0] a_word, b_eff, add_sum;
  logic             add_cout;
  logic             last_word;

  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
      assign a_words[gi] = a_q[gi*WIDTH +: WIDTH];
      assign b_words[gi] = b_q[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
  assign a_word    = a_words[idx_q];
  assign b_eff     = sub_q ? ~b_words[idx_q] : b_words[idx_q];
  assign last_word = (idx_q == IDXW'(NUM_WORDS - 1));

  adderN #(.WIDTH(WIDTH)) u_adder (
    .a_i    (a_word),
    .b_i    (b_eff),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          idx_d   = '0;
          carry_d = sub ? 1'b1 : cin;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          if (idx_q == IDXW'(i)) sum_d[i*WIDTH +: WIDTH] = add_sum;
        end
        carry_d = add_cout;
        if (last_word) begin
          cout_d  = add_cout;
          ovf_d   = (a_word[WIDTH-1] == b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != a_word[WIDTH-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed-vector bench for mp_add_seq (WIDTH=8, NUM_WORDS=4).
module tb_mp_add_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sub;
  logic        cin;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  mp_add_seq #(.WIDTH(8), .NUM_WORDS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sub   (sub),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // One operation; optionally pulses start with other operands in RUN cycle 2.
  task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input logic cv, input logic [31:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf, input bit inject);
    int lat, busy_cnt, done_cnt;
    lat = 0; done_cnt = 0;
    @(negedge clk);
    a = av; b = bv; sub = sv; cin = cv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_cnt = busy ? 1 : 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; lat = i; end
      if (inject && i == 2) begin
        start = 1'b1; a = 32'hAAAAAAAA; b = 32'h55555555; sub = ~sv; cin = ~cv;
      end
      if (inject && i == 3) start = 1'b0;
    end
    chk({name, ".sum"}, 64'(sum), 64'(exp_sum));
    chk({name, ".cout"}, 64'(cout), 64'(exp_cout));
    chk({name, ".ovf"}, 64'(ovf), 64'(exp_ovf));
    chk({name, ".latency"}, 64'(lat), 64'd4);
    chk({name, ".busy_cycles"}, 64'(busy_cnt), 64'd5);
    chk({name, ".done_pulses"}, 64'(done_cnt), 64'd1);
    $display("op %s a=%08h b=%08h sub=%0d cin=%0d -> sum=%08h cout=%0d ovf=%0d",
             name, av, bv, sv, cv, sum, cout, ovf);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.sum",  64'(sum),  64'd0);
    chk("rst.cout", 64'(cout), 64'd0);
    chk("rst.ovf",  64'(ovf),  64'd0);
    $display("reset released");
    @(negedge clk);
    reset = 1'b0;

    run_op("carry_word", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 0);
    run_op("wrap",       32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 0);
    run_op("sovf",       32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 0);
    run_op("sub_borrow", 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 0);
    run_op("carry_in",   32'h12345678, 32'h11111111, 1'b0, 1'b1, 32'h2345678A, 1'b0, 1'b0, 0);
    run_op("sub_equal",  32'h12345678, 32'h12345678, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 0);
    run_op("sub_sovf",   32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 0);
    run_op("ignore_start", 32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0, 1);

    // Leave ovf=1 behind, then abort mid-RUN after two words are written.
    run_op("pre_abort",  32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 0);
    @(negedge clk);
    a = 32'h11111111; b = 32'h11111111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort.partial_sum", 64'(sum), 64'h00002222);
    reset = 1'b1;
    #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.sum",  64'(sum),  64'd0);
    chk("abort.cout", 64'(cout), 64'd0);
    chk("abort.ovf",  64'(ovf),  64'd0);
    $display("reset asserted mid-run");
    @(negedge clk);
    reset = 1'b0;
    run_op("post_abort", 32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
